// File: rtl/mult_module.sv
// Iterative signed multiplier using radix-4 Booth recoding. It retires 2 multiplier bits per cycle
// and returns product[WIDTH-1:0] together with a signed-overflow flag. Define MULT_EARLY_TERM_EN to stop early once all remaining Booth digits are zero.
module mult_module #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_inputRDY,
  output logic             data_resultRDY
);

  localparam int ITERS = WIDTH / 2;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_next;
  logic [PW-1:0]    mcand, prod, addend, prod_next;
  logic [WIDTH-1:0] mplier, mplier_next;
  logic             prev;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH:0]   upper;
  logic             start, step_last, exc_next;

  assign data_inputRDY = (state == IDLE) || (state == DONE);
  assign start         = ctrl_MULT && data_inputRDY;

  always_comb begin
    addend = '0;
    case ({mplier[1:0], prev})
      3'b001, 3'b010: addend = mcand;
      3'b011:         addend = mcand << 1;
      3'b100:         addend = (~(mcand << 1)) + PW'(1);
      3'b101, 3'b110: addend = (~mcand) + PW'(1);
      default:        addend = '0;
    endcase
  end

  assign prod_next   = prod + addend;
  assign mplier_next = $signed(mplier) >>> 2;
  assign count_next  = count + CW'(1);

  // Product fits in WIDTH signed bits only when the top WIDTH+1 bits are all equal.
  assign upper    = prod_next[PW-1:WIDTH-1];
  assign exc_next = ~(&upper | ~|upper);

`ifdef MULT_EARLY_TERM_EN
  assign step_last = (count_next == CW'(ITERS))
                   || (~|mplier_next && !mplier[1])
                   || (&mplier_next && mplier[1]);
`else
  assign step_last = (count_next == CW'(ITERS));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl_MULT) state_next = BUSY;
      BUSY:    if (step_last) state_next = DONE;
      DONE:    state_next = ctrl_MULT ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand          <= '0;
      mplier         <= '0;
      prev           <= 1'b0;
      prod           <= '0;
      count          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
        mplier <= data_operandB;
        prev   <= 1'b0;
        prod   <= '0;
        count  <= '0;
      end else if (state == BUSY) begin
        prod   <= prod_next;
        mcand  <= mcand << 2;
        prev   <= mplier[1];
        mplier <= mplier_next;
        count  <= count_next;
        if (step_last) begin
          data_result    <= prod_next[WIDTH-1:0];
          data_exception <= exc_next;
          data_resultRDY <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_module.sv
// Scoreboard bench for mult_module: the driver pushes reference products, and the monitor pops an entry on each resultRDY pulse.
module tb_mult_module;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] opa, opb;
  logic        ctrl;
  logic [31:0] data_result;
  logic        data_exception, data_inputRDY, data_resultRDY;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mult_module #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(opa), .data_operandB(opb), .ctrl_MULT(ctrl),
    .data_result(data_result), .data_exception(data_exception),
    .data_inputRDY(data_inputRDY), .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: exact 64-bit signed product from plain arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int s);
    exp_t   e;
    longint p;
    logic [63:0] pb;
    p  = longint'($signed(a)) * longint'($signed(b));
    pb = p;
    e.res   = pb[31:0];
    e.exc   = (p != longint'($signed(pb[31:0])));
    e.start = s;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    int   lat;
    if (data_resultRDY) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_resultRDY actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e   = q.pop_front();
        lat = cyc - e.start;
        chk("result", data_result, e.res);
        chk("exception", {31'b0, data_exception}, {31'b0, e.exc});
        chk("inputRDY_in_done", {31'b0, data_inputRDY}, 32'd1);
`ifdef MULT_EARLY_TERM_EN
        checks++;
        if (lat < 1 || lat > 16) begin
          errors++;
          $display("FAIL latency actual=%0d expected=1..16", lat);
        end
`else
        chk("latency", lat, 32'd16);
`endif
      end
    end
  end

  // Called at a negedge: drive a one-cycle start and record the expectation.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    opa  = a;
    opb  = b;
    ctrl = 1'b1;
    q.push_back(model(a, b, cyc + 1));
    @(negedge clock);
    ctrl = 1'b0;
    opa  = $urandom;
    opb  = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
    chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    drain();
  endtask

  logic [31:0] va[10] = '{32'd7, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h80000000,
                          32'd5, 32'd9, 32'd12345, 32'h7FFFFFFF, 32'd0};
  logic [31:0] vb[10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 32'd1,
                          32'd3, 32'hFFFFFFFF, 32'd0, 32'h80000000, 32'h80000000};

  initial begin
    reset = 1'b1;
    ctrl  = 1'b0;
    opa   = '0;
    opb   = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'b0, data_exception}, 32'd0);
    chk("reset_resultRDY", {31'b0, data_resultRDY}, 32'd0);
    chk("reset_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_op(va[i], vb[i]);

    // A second start while busy must be ignored.
    issue(32'd1234567, 32'h5A5A5A5A);
    repeat (4) @(negedge clock);
    chk("inputRDY_in_busy", {31'b0, data_inputRDY}, 32'd0);
    opa  = 32'd3;
    opb  = 32'd3;
    ctrl = 1'b1;
    @(negedge clock);
    ctrl = 1'b0;
    drain();
    repeat (3) @(negedge clock);

    // Back-to-back: a start raised during DONE is accepted.
    issue(32'hDEADBEEF, 32'h12345678);
    for (int i = 0; i < 40 && !data_resultRDY; i++) @(negedge clock);
    chk("b2b_first_done", {31'b0, data_resultRDY}, 32'd1);
    issue(32'hFFFF0001, 32'h00007FFF);
    drain();

    // Reset mid-operation: the product is discarded and outputs return to reset values.
    issue(32'h00012345, 32'h00054321);
    repeat (7) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    q.delete();
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_exception", {31'b0, data_exception}, 32'd0);
    chk("midreset_inputRDY", {31'b0, data_inputRDY}, 32'd1);
    chk("midreset_resultRDY", {31'b0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 1000) - 500;
        1: b = $urandom_range(0, 1000) - 500;
        2: a = 32'h80000000;
        3: b = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
        default: ;
      endcase
      run_op(a, b);
    end

    repeat (5) @(negedge clock);
    chk("queue_empty_at_end", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
